// File: rtl/ldm_stm_sequencer_if.sv
// Memory-side handshake between the LDM/STM sequencer (master) and the data memory port (slave).
interface ldm_stm_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Load/Store Multiple sequencer: walks a 16-bit register list lowest-first, one memory
// handshake per word, and produces register-file strobes plus the optional base writeback.
module ldm_stm_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [31:0]         ir,
   input  logic [16:0]         fam,
   input  logic [ADDR_W-1:0]   base_val,
   output logic                busy,
   ldm_stm_sequencer_if.master bus,
   output logic [3:0]          reg_idx,
   output logic                reg_we,
   output logic [DATA_W-1:0]   reg_wdata,
   output logic                base_we,
   output logic [3:0]          base_idx,
   output logic [ADDR_W-1:0]   base_wdata,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

   state_t            state;
   logic              p, u, w, l;
   logic [15:0]       rl;
   logic [15:0]       rem;
   logic [ADDR_W-1:0] base_r;

   logic [4:0]        n;
   logic [ADDR_W-1:0] four_n;
   logic [ADDR_W-1:0] first_addr;
   logic [ADDR_W-1:0] wb_val;
   logic [15:0]       rem_nx;

   // S bit, condition field and the other decode families are handled elsewhere.
   logic unused_ok;
   assign unused_ok = ^{ir[31:25], ir[22], fam[16:15], fam[13:0]};

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      popcount16 = '0;
      for (int i = 0; i < 16; i++) popcount16 = popcount16 + 5'(v[i]);
   endfunction

   function automatic logic [3:0] lowest_bit(input logic [15:0] v);
      lowest_bit = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) lowest_bit = 4'(i);
   endfunction

   assign n      = popcount16(rl);
   assign four_n = ADDR_W'(n) << 2;
   // Clearing the lowest set bit moves the pointer to the next register in the list.
   assign rem_nx = rem & (rem - 16'd1);

   always_comb begin
      first_addr = base_r;
      unique case ({p, u})
         2'b01: first_addr = base_r;
         2'b11: first_addr = base_r + ADDR_W'(4);
         2'b00: first_addr = base_r - four_n + ADDR_W'(4);
         2'b10: first_addr = base_r - four_n;
      endcase
      wb_val = u ? base_r + four_n : base_r - four_n;
   end

   // NOTE: every register here uses <= so all updates in a cycle see the pre-edge values;
   // a blocking = would let later statements observe half-updated state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: reset clears every output and control register, data included, so an
         // abandoned transfer leaves nothing on the ports (there is no storage array here).
         state        <= IDLE;
         busy         <= 1'b0;
         bus.mem_req  <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
         reg_idx      <= '0;
         reg_we       <= 1'b0;
         reg_wdata    <= '0;
         base_we      <= 1'b0;
         base_idx     <= '0;
         base_wdata   <= '0;
         done         <= 1'b0;
         p            <= 1'b0;
         u            <= 1'b0;
         w            <= 1'b0;
         l            <= 1'b0;
         rl           <= '0;
         rem          <= '0;
         base_r       <= '0;
      end else begin
         reg_we  <= 1'b0;
         base_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start && fam[14]) begin
                  p        <= ir[24];
                  u        <= ir[23];
                  w        <= ir[21];
                  l        <= ir[20];
                  base_idx <= ir[19:16];
                  rl       <= ir[15:0];
                  base_r   <= base_val;
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               rem          <= rl;
               bus.mem_addr <= first_addr;
               bus.mem_we   <= ~l;
               base_wdata   <= wb_val;
               reg_idx      <= lowest_bit(rl);
               if (n == 5'd0) begin
                  done    <= 1'b1;
                  base_we <= w;
                  state   <= FINISH;
               end else begin
                  bus.mem_req <= 1'b1;
                  state       <= XFER;
               end
            end
            XFER: begin
               // Loads keep reg_idx one word behind so it matches the reg_we pulse.
               if (l) reg_idx <= lowest_bit(rem);
               if (bus.mem_ack) begin
                  bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
                  rem          <= rem_nx;
                  if (l) begin
                     reg_we    <= 1'b1;
                     reg_wdata <= bus.mem_rdata;
                  end else begin
                     reg_idx <= lowest_bit(rem_nx);
                  end
                  if (rem_nx == '0) begin
                     bus.mem_req <= 1'b0;
                     done        <= 1'b1;
                     base_we     <= w & ~(l & rl[base_idx]);
                     state       <= FINISH;
                  end
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed cases plus randomized LDM/STM
// operations compared against an address/register list model built from the instruction.
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] ir;
   logic [16:0] fam;
   logic [31:0] base_val;
   logic        busy;
   logic [3:0]  reg_idx;
   logic        reg_we;
   logic [31:0] reg_wdata;
   logic        base_we;
   logic [3:0]  base_idx;
   logic [31:0] base_wdata;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   ldm_stm_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ir         (ir),
      .fam        (fam),
      .base_val   (base_val),
      .busy       (busy),
      .bus        (bus),
      .reg_idx    (reg_idx),
      .reg_we     (reg_we),
      .reg_wdata  (reg_wdata),
      .base_we    (base_we),
      .base_idx   (base_idx),
      .base_wdata (base_wdata),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},       32'(busy),         32'd0);
      check({tag, "_mem_req"},    32'(bus.mem_req),  32'd0);
      check({tag, "_mem_we"},     32'(bus.mem_we),   32'd0);
      check({tag, "_mem_addr"},   bus.mem_addr,      32'd0);
      check({tag, "_reg_idx"},    32'(reg_idx),      32'd0);
      check({tag, "_reg_we"},     32'(reg_we),       32'd0);
      check({tag, "_reg_wdata"},  reg_wdata,         32'd0);
      check({tag, "_base_we"},    32'(base_we),      32'd0);
      check({tag, "_base_idx"},   32'(base_idx),     32'd0);
      check({tag, "_base_wdata"}, base_wdata,        32'd0);
      check({tag, "_done"},       32'(done),         32'd0);
   endtask

   // Runs one accepted operation in lock-step with the DUT. Word k of the list gets an
   // ack after a random wait in [dmin,dmax]; its load data is rd0 + k*0x1111.
   task automatic run_op(input logic [31:0] ir_v, input logic [31:0] base_v,
                         input int dmin, input int dmax, input logic [31:0] rd0);
      logic        p, u, w, l;
      logic [3:0]  rn;
      logic [15:0] rl;
      int          regs[$];
      int          n, d, sumd, cyc;
      logic [31:0] exp_addr, exp_wb, data_k, prev_data;
      logic        exp_we, exp_base_we;
      int          prev_reg;
      p  = ir_v[24];
      u  = ir_v[23];
      w  = ir_v[21];
      l  = ir_v[20];
      rn = ir_v[19:16];
      rl = ir_v[15:0];
      for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
      n           = regs.size();
      exp_wb      = u ? base_v + 32'(4 * n) : base_v - 32'(4 * n);
      exp_base_we = w && !(l && rl[rn]);
      sumd        = 0;
      exp_we      = 1'b0;
      prev_reg    = 0;
      prev_data   = '0;

      @(negedge clk);
      start    = 1'b1;
      ir       = ir_v;
      fam      = 17'h04000;
      base_val = base_v;
      @(negedge clk);
      start    = 1'b0;
      ir       = $urandom;
      base_val = $urandom;
      cyc      = 1;
      check("setup_busy", 32'(busy), 32'd1);
      check("setup_req",  32'(bus.mem_req), 32'd0);

      for (int k = 0; k < n; k++) begin
         // Lowest register sits at the lowest address; the block is anchored by P/U.
         exp_addr = u ? base_v + 32'(4 * (k + int'(p)))
                      : base_v - 32'(4 * (n - k)) + 32'(4 * (1 - int'(p)));
         d      = $urandom_range(dmax, dmin);
         sumd  += d;
         data_k = rd0 + 32'(k) * 32'h1111;
         for (int j = 0; j <= d; j++) begin
            @(negedge clk);
            cyc++;
            check("xfer_req",    32'(bus.mem_req), 32'd1);
            check("xfer_addr",   bus.mem_addr, exp_addr);
            check("xfer_we",     32'(bus.mem_we), 32'(!l));
            check("xfer_reg_we", 32'(reg_we), 32'(exp_we));
            if (exp_we) begin
               check("load_idx",   32'(reg_idx), 32'(prev_reg));
               check("load_wdata", reg_wdata, prev_data);
            end else begin
               check("xfer_idx",   32'(reg_idx), 32'(regs[k]));
            end
            bus.mem_ack   = (j == d);
            bus.mem_rdata = (j == d) ? data_k : $urandom;
            exp_we        = l && (j == d);
            prev_reg      = regs[k];
            prev_data     = data_k;
         end
      end

      @(negedge clk);
      cyc++;
      bus.mem_ack = 1'b0;
      check("fin_done",    32'(done), 32'd1);
      check("fin_busy",    32'(busy), 32'd1);
      check("fin_req",     32'(bus.mem_req), 32'd0);
      check("fin_latency", 32'(cyc), 32'(2 + n + sumd));
      check("fin_reg_we",  32'(reg_we), 32'(exp_we));
      if (exp_we) begin
         check("fin_load_idx",   32'(reg_idx), 32'(prev_reg));
         check("fin_load_wdata", reg_wdata, prev_data);
      end
      check("fin_base_we",  32'(base_we), 32'(exp_base_we));
      check("fin_base_idx", 32'(base_idx), 32'(rn));
      if (exp_base_we) check("fin_base_wdata", base_wdata, exp_wb);

      @(negedge clk);
      check("idle_busy",    32'(busy), 32'd0);
      check("idle_done",    32'(done), 32'd0);
      check("idle_base_we", 32'(base_we), 32'd0);
      check("idle_reg_we",  32'(reg_we), 32'd0);
   endtask

   initial begin
      logic [31:0] r_ir;
      rst_n         = 1'b0;
      start         = 1'b0;
      ir            = '0;
      fam           = '0;
      base_val      = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // STMIA r1!, {r1-r3}
      run_op(32'hE8A1_000E, 32'h0000_1000, 0, 0, 32'h0);
      // LDMDB r2, {r0,r15}
      run_op(32'hE912_8001, 32'h0000_2000, 0, 0, 32'h0000_AAAA);
      // LDMIB r3, {r4} with three wait states
      run_op(32'hE993_0010, 32'h0000_0100, 3, 3, 32'h1234_5678);
      // STMIA r1!, {} : no memory access
      run_op(32'hE8A1_0000, 32'h0000_0500, 0, 0, 32'h0);
      // LDMDA r5!, {r0,r1} wrapping through zero
      run_op(32'hE835_0003, 32'h0000_0004, 0, 0, 32'h0000_0042);
      // LDMIA r1!, {r1,r2}: loaded base wins over writeback
      run_op(32'hE8B1_0006, 32'h0000_7000, 0, 1, 32'h0000_0900);

      // Start outside the LDM/STM family is ignored
      @(negedge clk);
      start = 1'b1;
      ir    = 32'hE8A1_000E;
      fam   = 17'h00200;
      repeat (2) begin
         @(negedge clk);
         check("ignored_busy", 32'(busy), 32'd0);
         check("ignored_req",  32'(bus.mem_req), 32'd0);
      end
      start = 1'b0;

      // Reset during the second of four stores
      @(negedge clk);
      start    = 1'b1;
      ir       = 32'hE8A0_000F;
      fam      = 17'h04000;
      base_val = 32'h0000_3000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_first_addr", bus.mem_addr, 32'h0000_3000);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      check("rst_second_addr", bus.mem_addr, 32'h0000_3004);
      bus.mem_ack = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      check_all_zero("midop_reset");
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_base_we", 32'(base_we), 32'd0);
         check("post_rst_busy",    32'(busy), 32'd0);
      end
      run_op(32'hE8A1_000E, 32'h0000_1000, 0, 0, 32'h0);

      // Randomized operations with random wait states
      for (int t = 0; t < 30; t++) begin
         r_ir = {4'hE, 3'b100, 5'($urandom), 4'($urandom), 16'($urandom & $urandom)};
         if (t % 7 == 3) r_ir[15:0] = 16'h0;
         run_op(r_ir, $urandom, 0, 2, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
